// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle unsigned subtractor: computes a - b as a + ~b + 1, one SLICE-bit
// carry-lookahead slice per clock, with valid/ready handshakes on both sides.
module nibble_serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             a_lt_b
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, nb_q, diff_q, diff_d;
    logic [CW-1:0]    count_q;
    logic             carry_q;
    logic             in_ready_q, out_valid_q, borrow_q, zero_q, a_lt_b_q;

    logic [SLICE-1:0] p, g, sum;
    logic [SLICE:0]   c;

    // Carry into bit i+1 as a flat sum of products over the slice (no ripple chain).
    function automatic logic cla_carry(input logic [SLICE-1:0] pv,
                                       input logic [SLICE-1:0] gv,
                                       input logic cin, input int i);
        logic res;
        logic prod;
        res = 1'b0;
        for (int j = -1; j <= i; j++) begin
            prod = (j < 0) ? cin : gv[j];
            for (int k = j + 1; k <= i; k++) begin
                prod = prod & pv[k];
            end
            res = res | prod;
        end
        return res;
    endfunction

    assign c[0] = carry_q;

    genvar gi;
    generate
        for (gi = 0; gi < SLICE; gi++) begin : g_slice
            assign p[gi]     = a_q[gi] ^ nb_q[gi];
            assign g[gi]     = a_q[gi] & nb_q[gi];
            assign c[gi + 1] = cla_carry(p, g, carry_q, gi);
            assign sum[gi]   = p[gi] ^ c[gi];
        end
    endgenerate

    always_comb begin
        diff_d = diff_q;
        diff_d[count_q * SLICE +: SLICE] = sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b0;
            a_lt_b_q    <= 1'b0;
            count_q     <= '0;
            carry_q     <= 1'b1;
            a_q         <= '0;
            nb_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        nb_q       <= ~b;
                        carry_q    <= 1'b1;
                        count_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    // Operands shift down so the active slice always sits at bit 0.
                    diff_q  <= diff_d;
                    carry_q <= c[SLICE];
                    a_q     <= a_q >> SLICE;
                    nb_q    <= nb_q >> SLICE;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(N - 1)) begin
                        out_valid_q <= 1'b1;
                        borrow_q    <= ~c[SLICE];
                        a_lt_b_q    <= ~c[SLICE];
                        zero_q      <= (diff_d == '0);
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;
    assign a_lt_b    = a_lt_b_q;
endmodule
